// File: rtl/nios2_debug_slave_sysclk_cmd.sv
// System-clock half of the Nios II JTAG debug slave: synchronises the TCK-domain
// update strobes, latches the shifted command and pulses one per-instruction action line.
module nios2_debug_slave_sysclk_cmd #(
    parameter int DATA_WIDTH  = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ACTION_BIT  = 35,
    parameter int ACK_MODE    = 0,
    localparam int NCMD       = 2 ** IR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vs_udr,
    input  logic                  vs_uir,
    input  logic [IR_WIDTH-1:0]   ir_in,
    input  logic [DATA_WIDTH-1:0] sr,
    input  logic                  cmd_ack,
    input  logic                  overrun_clr,
    output logic [DATA_WIDTH-1:0] jdo,
    output logic [IR_WIDTH-1:0]   cmd_ir,
    output logic [NCMD-1:0]       take_action,
    output logic [NCMD-1:0]       take_no_action,
    output logic                  cmd_busy,
    output logic                  overrun
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FIRE = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_INIT = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] udr_sync_reg;
    logic [SYNC_STAGES-1:0] uir_sync_reg;
    logic                   udr_edge_reg;
    logic                   uir_edge_reg;
    logic                   udr_rise_reg;
    logic                   uir_rise_reg;
    logic [ARM_W-1:0]       arm_reg;
    logic                   armed;
    logic [IR_WIDTH-1:0]    ir_latched_reg;
    logic [1:0]             state_reg;
    logic [1:0]             state_next;
    logic [DATA_WIDTH-1:0]  jdo_reg;
    logic [IR_WIDTH-1:0]    cmd_ir_reg;
    logic                   cmd_busy_reg;
    logic                   overrun_reg;
    logic                   accept;
    logic                   fire;

    // Rise pulses are masked until the chains have flushed post-reset levels.
    assign armed = (arm_reg == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_sync_reg <= '0;
            uir_sync_reg <= '0;
            udr_edge_reg <= 1'b0;
            uir_edge_reg <= 1'b0;
            udr_rise_reg <= 1'b0;
            uir_rise_reg <= 1'b0;
            arm_reg      <= ARM_INIT;
        end else begin
            udr_sync_reg <= {udr_sync_reg[SYNC_STAGES-2:0], vs_udr};
            uir_sync_reg <= {uir_sync_reg[SYNC_STAGES-2:0], vs_uir};
            udr_edge_reg <= udr_sync_reg[SYNC_STAGES-1];
            uir_edge_reg <= uir_sync_reg[SYNC_STAGES-1];
            udr_rise_reg <= udr_sync_reg[SYNC_STAGES-1] & ~udr_edge_reg & armed;
            uir_rise_reg <= uir_sync_reg[SYNC_STAGES-1] & ~uir_edge_reg & armed;
            if (!armed) begin
                arm_reg <= arm_reg - 1'b1;
            end
        end
    end

    assign accept = (state_reg == IDLE) && udr_rise_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (udr_rise_reg) state_next = FIRE;
            FIRE:    state_next = (ACK_MODE != 0) ? WAIT : IDLE;
            WAIT:    if (cmd_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cmd_busy_reg   <= 1'b0;
            jdo_reg        <= '0;
            cmd_ir_reg     <= '0;
            ir_latched_reg <= '0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cmd_busy_reg <= (state_next != IDLE);
            // cmd_ir samples the pre-update ir_latched when both strobes coincide.
            if (accept) begin
                jdo_reg    <= sr;
                cmd_ir_reg <= ir_latched_reg;
            end
            if (uir_rise_reg) begin
                ir_latched_reg <= ir_in;
            end
            if (udr_rise_reg && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end else if (overrun_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign fire = (state_reg == FIRE);

    for (genvar gi = 0; gi < NCMD; gi++) begin : g_take
        assign take_action[gi]    = fire && (cmd_ir_reg == IR_WIDTH'(gi)) &&  jdo_reg[ACTION_BIT];
        assign take_no_action[gi] = fire && (cmd_ir_reg == IR_WIDTH'(gi)) && !jdo_reg[ACTION_BIT];
    end

    assign jdo      = jdo_reg;
    assign cmd_ir   = cmd_ir_reg;
    assign cmd_busy = cmd_busy_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_nios2_debug_slave_sysclk_cmd.sv
// Scoreboard bench: one fire-and-forget and one acknowledged instance share stimulus;
// an event-level model predicts every pulse, its cycle, and the overrun flag.
module tb_nios2_debug_slave_sysclk_cmd;

    localparam int S = 2;

    typedef struct {
        int          fire;
        logic [37:0] data;
        logic [1:0]  ir;
        bit          act;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs_udr = 1'b1;
    logic        vs_uir = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic        cmd_ack = 1'b0;
    logic        overrun_clr = 1'b0;

    logic [37:0] jdo0, jdo1;
    logic [1:0]  cmd_ir0, cmd_ir1;
    logic [3:0]  ta0, ta1, tn0, tn1;
    logic        busy0, busy1, ov0, ov1;

    nios2_debug_slave_sysclk_cmd #(.ACK_MODE(0)) dut0 (
        .clk(clk), .reset(rst), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
        .cmd_ack(cmd_ack), .overrun_clr(overrun_clr), .jdo(jdo0), .cmd_ir(cmd_ir0),
        .take_action(ta0), .take_no_action(tn0), .cmd_busy(busy0), .overrun(ov0));

    nios2_debug_slave_sysclk_cmd #(.ACK_MODE(1)) dut1 (
        .clk(clk), .reset(rst), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
        .cmd_ack(cmd_ack), .overrun_clr(overrun_clr), .jdo(jdo1), .cmd_ir(cmd_ir1),
        .take_action(ta1), .take_no_action(tn1), .cmd_busy(busy1), .overrun(ov1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: index 0 = fire-and-forget instance, 1 = acknowledged instance.
    exp_t        q0[$];
    exp_t        q1[$];
    int          idle_from[2] = '{0, 0};
    bit          pend = 1'b0;
    int          pend_fire = 0;
    bit          exp_ov[2] = '{1'b0, 1'b0};
    int          ov_edge[2] = '{-1, -1};
    logic [37:0] last_jdo[2] = '{38'd0, 38'd0};
    logic [1:0]  ir_old = '0;
    logic [1:0]  ir_new = '0;
    int          ir_eff = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ir_at(input int t);
        return (t > ir_eff) ? ir_new : ir_old;
    endfunction

    // A udr strobe becomes effective at edge t; accepted only if that instance is idle.
    task automatic model_udr(input int t, input logic [37:0] d);
        exp_t e;
        e.fire = t;
        e.data = d;
        e.ir   = ir_at(t);
        e.act  = d[35];
        for (int m = 0; m < 2; m++) begin
            if (t >= idle_from[m]) begin
                last_jdo[m] = d;
                if (m == 0) begin
                    q0.push_back(e);
                    idle_from[0] = t + 2;
                end else begin
                    q1.push_back(e);
                    idle_from[1] = 32'h7fff_ffff;
                    pend = 1'b1;
                    pend_fire = t;
                end
            end else begin
                exp_ov[m]  = 1'b1;
                ov_edge[m] = t;
            end
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        idle_from = '{0, 0};
        pend = 1'b0;
        exp_ov = '{1'b0, 1'b0};
        ov_edge = '{-1, -1};
        last_jdo = '{38'd0, 38'd0};
        ir_old = '0;
        ir_new = '0;
        ir_eff = 0;
    endtask

    task automatic strobe(input bit do_uir, input logic [1:0] ir_v, input bit do_udr,
                          input logic [37:0] d);
        int t;
        @(negedge clk);
        t = cyc + 1 + S + 1;
        if (do_udr) begin
            sr = d;
            vs_udr = 1'b1;
            model_udr(t, d);
        end
        if (do_uir) begin
            ir_in = ir_v;
            vs_uir = 1'b1;
            ir_old = ir_at(t);
            ir_new = ir_v;
            ir_eff = t;
        end
        repeat (2) @(negedge clk);
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ack();
        int e;
        @(negedge clk);
        cmd_ack = 1'b1;
        e = cyc + 1;
        if (pend && e >= pend_fire + 2) begin
            pend = 1'b0;
            idle_from[1] = e + 1;
        end
        @(negedge clk);
        cmd_ack = 1'b0;
    endtask

    task automatic clr();
        int e;
        @(negedge clk);
        overrun_clr = 1'b1;
        e = cyc + 1;
        for (int m = 0; m < 2; m++) begin
            if (ov_edge[m] != e) exp_ov[m] = 1'b0;
        end
        @(negedge clk);
        overrun_clr = 1'b0;
    endtask

    task automatic pop(input int m, input logic [37:0] j, input logic [1:0] ir,
                       input logic [3:0] ta, input logic [3:0] tn, input logic b);
        exp_t e;
        bit   empty;
        empty = (m == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pulse dut%0d cyc %0d: got take_action=%b take_no_action=%b, required none",
                     m, cyc, ta, tn);
            return;
        end
        if (m == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        $display("dut%0d cmd: cyc %0d ir %0d jdo %0h action %0b", m, cyc, ir, j, e.act);
        chk($sformatf("dut%0d fire_cycle", m), 64'(cyc), 64'(e.fire));
        chk($sformatf("dut%0d jdo", m), 64'(j), 64'(e.data));
        chk($sformatf("dut%0d cmd_ir", m), 64'(ir), 64'(e.ir));
        chk($sformatf("dut%0d take_action", m), 64'(ta), e.act ? 64'(4'b1 << e.ir) : 64'd0);
        chk($sformatf("dut%0d take_no_action", m), 64'(tn), e.act ? 64'd0 : 64'(4'b1 << e.ir));
        chk($sformatf("dut%0d busy_in_fire", m), 64'(b), 64'd1);
    endtask

    always @(negedge clk) begin
        if ((ta0 | tn0) != 4'd0) pop(0, jdo0, cmd_ir0, ta0, tn0, busy0);
        if ((ta1 | tn1) != 4'd0) pop(1, jdo1, cmd_ir1, ta1, tn1, busy1);
    end

    task automatic chk_zeroed(input string tag);
        chk({tag, " jdo0"}, 64'(jdo0), 64'd0);
        chk({tag, " jdo1"}, 64'(jdo1), 64'd0);
        chk({tag, " cmd_ir"}, 64'({cmd_ir0, cmd_ir1}), 64'd0);
        chk({tag, " take"}, 64'({ta0, tn0, ta1, tn1}), 64'd0);
        chk({tag, " busy"}, 64'({busy0, busy1}), 64'd0);
        chk({tag, " overrun"}, 64'({ov0, ov1}), 64'd0);
    endtask

    task automatic chk_ov(input string tag);
        chk({tag, " overrun0"}, 64'(ov0), 64'(exp_ov[0]));
        chk({tag, " overrun1"}, 64'(ov1), 64'(exp_ov[1]));
    endtask

    initial begin
        logic [37:0] d;
        // Strobe held high through and after reset must never produce a command.
        repeat (3) @(negedge clk);
        chk_zeroed("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_udr busy", 64'({busy0, busy1}), 64'd0);
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);

        strobe(1, 2'd1, 0, '0);
        strobe(0, '0, 1, 38'h08_0000_1234);
        repeat (4) @(negedge clk);
        chk("wait busy1", 64'(busy1), 64'(pend));
        chk("wait busy0", 64'(busy0), 64'd0);
        ack();
        repeat (2) @(negedge clk);
        chk("acked busy1", 64'(busy1), 64'(pend));

        strobe(1, 2'd3, 0, '0);
        strobe(0, '0, 1, 38'h00_0000_5678);
        repeat (4) @(negedge clk);
        ack();

        // Second update while waiting for ack is dropped by the acknowledged instance.
        strobe(0, '0, 1, 38'h2a_1111_1111);
        repeat (4) @(negedge clk);
        strobe(0, '0, 1, 38'h15_2222_2222);
        repeat (4) @(negedge clk);
        chk_ov("drop");
        chk("drop jdo1", 64'(jdo1), 64'(last_jdo[1]));
        chk("drop jdo0", 64'(jdo0), 64'(last_jdo[0]));
        ack();
        clr();
        repeat (2) @(negedge clk);
        chk_ov("cleared");

        strobe(0, '0, 1, 38'h0f_3333_3333);
        repeat (4) @(negedge clk);
        fork
            strobe(0, '0, 1, 38'h30_4444_4444);
            begin
                repeat (3) @(negedge clk);
                clr();
            end
        join
        repeat (2) @(negedge clk);
        chk_ov("set_beats_clr");
        clr();
        ack();

        strobe(1, 2'd1, 0, '0);
        strobe(1, 2'd2, 1, 38'h08_5555_0001);
        repeat (4) @(negedge clk);
        ack();
        strobe(0, '0, 1, 38'h00_5555_0002);
        repeat (4) @(negedge clk);
        ack();

        // Asynchronous reset while the acknowledged instance sits in WAIT.
        strobe(0, '0, 1, 38'h3f_6666_6666);
        repeat (4) @(negedge clk);
        chk("pre_reset busy1", 64'(busy1), 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zeroed("async_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        strobe(0, '0, 1, 38'h08_7777_7777);
        repeat (4) @(negedge clk);
        ack();

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0) strobe(1, 2'($urandom_range(0, 3)), 0, '0);
            d = {6'($urandom), $urandom};
            strobe($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 1, d);
            repeat ($urandom_range(2, 4)) @(negedge clk);
            if ($urandom_range(0, 3) != 0) ack();
            if ($urandom_range(0, 4) == 0) clr();
        end

        repeat (10) @(negedge clk);
        chk_ov("final");
        chk("pending q0", 64'(q0.size()), 64'd0);
        chk("pending q1", 64'(q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
